// File: rtl/station_pkg.sv
// Shared types and opcode encodings for the station command controller.
package station_pkg;

    typedef enum logic {
        IDLE,
        TRANSIT
    } cntrl_state_t;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

endpackage

// File: rtl/buzz_gen.sv
// Piezo buzzer square-wave generator; runs only while enabled, otherwise held cleared.
module buzz_gen #(
    parameter int unsigned BUZZ_HALF = 6250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic buzz,
    output logic buzz_n
);

    logic [12:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            buzz <= 1'b0;
        end else if (cnt == 13'(BUZZ_HALF - 1)) begin
            cnt  <= '0;
            buzz <= ~buzz;
        end else begin
            cnt  <= cnt + 13'd1;
        end
    end

    assign buzz_n = ~buzz;

endmodule

// File: rtl/station_cmd_cntrl.sv
// Command controller: accepts UART commands and barcode station IDs, stops at the
// destination station, gates motion on OK2Move and sounds the buzzer while blocked.
module station_cmd_cntrl
    import station_pkg::*;
#(
    parameter int unsigned BUZZ_HALF = 6250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_rdy,
    input  logic [7:0] cmd,
    output logic       clr_cmd_rdy,
    input  logic       ID_vld,
    input  logic [7:0] ID,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       go,
    output logic       in_transit,
    output logic       buzz,
    output logic       buzz_n
);

    cntrl_state_t state, state_nxt;
    logic [5:0]   dest, dest_nxt;
    logic         cmd_acc, id_acc;

    // A request is taken only while its clear pulse is low, so the cycle that
    // acknowledges it cannot take it a second time.
    assign cmd_acc = cmd_rdy & ~clr_cmd_rdy;
    assign id_acc  = ID_vld & ~clr_ID_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dest        <= '0;
            clr_cmd_rdy <= 1'b0;
            clr_ID_vld  <= 1'b0;
        end else begin
            state       <= state_nxt;
            dest        <= dest_nxt;
            clr_cmd_rdy <= cmd_acc;
            clr_ID_vld  <= id_acc;
        end
    end

    // A command in the same cycle as an ID wins; that ID is acknowledged but not compared.
    always_comb begin
        state_nxt = state;
        dest_nxt  = dest;
        if (cmd_acc) begin
            case (cmd[7:6])
                OP_GO: begin
                    state_nxt = TRANSIT;
                    dest_nxt  = cmd[5:0];
                end
                OP_STOP: state_nxt = IDLE;
                default: ;
            endcase
        end else if (id_acc && state == TRANSIT && ID == {2'b00, dest}) begin
            state_nxt = IDLE;
        end
    end

    assign in_transit = (state == TRANSIT);
    assign go         = in_transit & OK2Move;

    buzz_gen #(
        .BUZZ_HALF(BUZZ_HALF)
    ) u_buzz_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (in_transit & ~OK2Move),
        .buzz   (buzz),
        .buzz_n (buzz_n)
    );

endmodule

// File: tb/tb_station_cmd_cntrl.sv
// Directed bench for station_cmd_cntrl with a short buzzer half-period.
module tb_station_cmd_cntrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_rdy;
    logic [7:0] cmd;
    logic       clr_cmd_rdy;
    logic       ID_vld;
    logic [7:0] ID;
    logic       clr_ID_vld;
    logic       OK2Move;
    logic       go;
    logic       in_transit;
    logic       buzz;
    logic       buzz_n;

    int n_pass  = 0;
    int n_total = 0;

    station_cmd_cntrl #(
        .BUZZ_HALF(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .clr_cmd_rdy (clr_cmd_rdy),
        .ID_vld      (ID_vld),
        .ID          (ID),
        .clr_ID_vld  (clr_ID_vld),
        .OK2Move     (OK2Move),
        .go          (go),
        .in_transit  (in_transit),
        .buzz        (buzz),
        .buzz_n      (buzz_n)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Requester drops its line only after seeing the clear pulse at a clock edge.
    task automatic send_cmd(input string tag, input logic [7:0] c, input logic exp_tr);
        cmd     = c;
        cmd_rdy = 1'b1;
        step();
        chk({tag, " clr_cmd_rdy pulse"}, clr_cmd_rdy, 1'b1);
        chk({tag, " in_transit"}, in_transit, exp_tr);
        step();
        chk({tag, " clr_cmd_rdy single"}, clr_cmd_rdy, 1'b0);
        chk({tag, " in_transit held"}, in_transit, exp_tr);
        cmd_rdy = 1'b0;
    endtask

    task automatic send_id(input string tag, input logic [7:0] id, input logic exp_tr);
        ID     = id;
        ID_vld = 1'b1;
        step();
        chk({tag, " clr_ID_vld pulse"}, clr_ID_vld, 1'b1);
        chk({tag, " in_transit"}, in_transit, exp_tr);
        step();
        chk({tag, " clr_ID_vld single"}, clr_ID_vld, 1'b0);
        chk({tag, " in_transit held"}, in_transit, exp_tr);
        ID_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_rdy = 1'b0; cmd = 8'h00; ID_vld = 1'b0; ID = 8'h00; OK2Move = 1'b1;
        step();
        step();
        chk("rst in_transit", in_transit, 1'b0);
        chk("rst go", go, 1'b0);
        chk("rst clr_cmd_rdy", clr_cmd_rdy, 1'b0);
        chk("rst clr_ID_vld", clr_ID_vld, 1'b0);
        chk("rst buzz", buzz, 1'b0);
        chk("rst buzz_n", buzz_n, 1'b1);
        rst = 1'b0;
        step();

        // GO to 0x05
        cmd = 8'h45; cmd_rdy = 1'b1;
        #1 chk("go05 pre in_transit", in_transit, 1'b0);
        cmd_rdy = 1'b0;
        send_cmd("go05", 8'h45, 1'b1);
        chk("go05 go", go, 1'b1);

        // Non-matching then matching station
        send_id("id03", 8'h03, 1'b1);
        chk("id03 go", go, 1'b1);
        send_id("id05", 8'h05, 1'b0);
        chk("id05 go", go, 1'b0);

        // Obstacle while in transit: buzzer
        send_cmd("go05b", 8'h45, 1'b1);
        chk("buzz idle", buzz, 1'b0);
        OK2Move = 1'b0;
        #1 chk("blocked go", go, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("buzz edge%0d", i), buzz, 1'((i / 4) % 2));
            chk($sformatf("buzz_n edge%0d", i), buzz_n, ~1'((i / 4) % 2));
        end
        OK2Move = 1'b1;
        #1 chk("unblocked go", go, 1'b1);
        step();
        chk("buzz cleared", buzz, 1'b0);
        chk("buzz_n cleared", buzz_n, 1'b1);

        // Simultaneous STOP command and matching ID
        cmd = 8'h3F; cmd_rdy = 1'b1; ID = 8'h05; ID_vld = 1'b1;
        step();
        chk("sim stop clr_cmd", clr_cmd_rdy, 1'b1);
        chk("sim stop clr_id", clr_ID_vld, 1'b1);
        chk("sim stop in_transit", in_transit, 1'b0);
        step();
        chk("sim stop clr_cmd single", clr_cmd_rdy, 1'b0);
        chk("sim stop clr_id single", clr_ID_vld, 1'b0);
        cmd_rdy = 1'b0; ID_vld = 1'b0;

        // Ignored inputs
        send_id("idle id05", 8'h05, 1'b0);
        send_cmd("idle stop", 8'h00, 1'b0);
        send_cmd("idle op3", 8'hC5, 1'b0);
        send_cmd("go05c", 8'h45, 1'b1);
        send_cmd("transit op2", 8'h80, 1'b1);
        send_id("dest kept", 8'h05, 1'b0);

        // Re-route with an ID for the old destination in the same cycle
        send_cmd("go05d", 8'h45, 1'b1);
        cmd = 8'h47; cmd_rdy = 1'b1; ID = 8'h05; ID_vld = 1'b1;
        step();
        chk("reroute clr_cmd", clr_cmd_rdy, 1'b1);
        chk("reroute clr_id", clr_ID_vld, 1'b1);
        chk("reroute in_transit", in_transit, 1'b1);
        step();
        cmd_rdy = 1'b0; ID_vld = 1'b0;
        send_id("old dest", 8'h05, 1'b1);
        send_id("new dest", 8'h07, 1'b0);

        // Reset mid-transit with a clear pulse pending
        send_cmd("go05e", 8'h45, 1'b1);
        ID = 8'h03; ID_vld = 1'b1;
        step();
        chk("pre-rst clr_id", clr_ID_vld, 1'b1);
        rst = 1'b1;
        step();
        chk("mid rst in_transit", in_transit, 1'b0);
        chk("mid rst go", go, 1'b0);
        chk("mid rst clr_id", clr_ID_vld, 1'b0);
        chk("mid rst clr_cmd", clr_cmd_rdy, 1'b0);
        chk("mid rst buzz_n", buzz_n, 1'b1);
        rst = 1'b0;
        step();
        chk("post rst clr_id", clr_ID_vld, 1'b1);
        chk("post rst in_transit", in_transit, 1'b0);
        step();
        chk("post rst clr_id single", clr_ID_vld, 1'b0);
        ID_vld = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/station_cmd_cntrl.md
# station_cmd_cntrl

Command controller for the line-follower digital core. It accepts 8-bit commands from the UART receiver, holds the destination station ID, and consumes station IDs from the barcode reader, clearing each `ID_vld`. It stops the robot when the read ID matches the destination, gates motion with the obstacle `OK2Move` signal, and drives a 4 kHz piezo buzzer while blocked in transit.

## Interface
Parameters:
- `BUZZ_HALF`, default 6250: clk cycles per buzzer half-period (50 MHz / 4 kHz / 2).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `cmd_rdy`  in  1  UART command available; held high until cleared.
- `cmd`  in  8  command. `[7:6]` is the opcode, `[5:0]` is the destination ID.
- `clr_cmd_rdy`  out  1  single-cycle pulse acknowledging `cmd_rdy`.
- `ID_vld`  in  1  barcode station ID valid; held high until cleared.
- `ID`  in  8  station ID from the barcode reader; `[7:6]` is guaranteed to be 2'b00.
- `clr_ID_vld`  out  1  single-cycle pulse acknowledging `ID_vld`.
- `OK2Move`  in  1  high when no obstacle is present.
- `go`  out  1  motion enable to the motor controller.
- `in_transit`  out  1  high while travelling toward the destination.
- `buzz`, `buzz_n`  out  1  differential piezo drive.

## Operation
- Opcodes:
  - 2'b01 GO: load `dest <= cmd[5:0]` and enter TRANSIT.
  - 2'b00 STOP: enter IDLE.
  - 2'b10 and 2'b11 are ignored but still acknowledged.
- States are IDLE and TRANSIT. `in_transit` is 1 exactly in TRANSIT.
- Accept rule: an input is accepted in cycle N when `cmd_rdy & ~clr_cmd_rdy` (likewise `ID_vld & ~clr_ID_vld`). The matching clear pulse is registered and high in cycle N+1 only. A still-high request in N+1 is not re-accepted.
- IDLE:
  - GO → TRANSIT.
  - STOP or other opcode → stay in IDLE.
  - Accepted ID is acknowledged and discarded.
- TRANSIT:
  - GO reloads `dest` and stays in TRANSIT (re-route).
  - STOP → IDLE.
  - Accepted ID with `ID[5:0]==dest` → IDLE.
  - Non-matching ID → acknowledged, stay in TRANSIT.
- Simultaneous command and ID accepted in the same cycle: both are acknowledged in N+1. The command decides the next state and `dest`; the ID is discarded without comparison.
- `go = in_transit & OK2Move` (combinational).
- Buzzer:
  - Active while `in_transit & ~OK2Move`.
  - 13-bit counter counts 0..`BUZZ_HALF`-1; `buzz` toggles on the wrap.
  - When inactive, counter and `buzz` clear to 0 on the next clk.
  - `buzz_n = ~buzz` always.

## Timing
- Reset values (all registers, synchronous on `rst`): state IDLE, `dest`=0, `clr_cmd_rdy`=0, `clr_ID_vld`=0, `buzz`=0, buzzer counter 0. Therefore `go`=0, `in_transit`=0, `buzz_n`=1.
- State and `dest` update in cycle N+1 after acceptance in cycle N; `in_transit` and `go` change in N+1.
- Reset asserted mid-transit or mid-acknowledge: state returns to IDLE next clk and any pending clear pulse is dropped. A request still high after reset is accepted normally.
- `OK2Move` change propagates to `go` in the same cycle. The buzzer starts counting on the next clk.
- First `buzz` rising edge occurs `BUZZ_HALF` clks after the buzzer activates. Full period is 2·`BUZZ_HALF`.

## Structure
- Package `station_pkg`:
  - `cntrl_state_t` enum {IDLE, TRANSIT}.
  - Opcode localparams `OP_STOP`=2'b00, `OP_GO`=2'b01.
- Sub-module `buzz_gen` contains the counter/toggle logic. Ports: `clk`, `rst`, `en`, `buzz`, `buzz_n`; parameter `BUZZ_HALF`.
- Top level holds the FSM, `dest` register and the acknowledge registers.

## Test plan
- GO to 0x05 (`cmd`=0x45 with `cmd_rdy`), `OK2Move`=1 → `clr_cmd_rdy` pulses one cycle; `in_transit`=1 and `go`=1 from the next cycle.
- In transit to 0x05, send ID 0x03 then ID 0x05 → each gets one `clr_ID_vld` pulse; stays in transit after 0x03; `in_transit`=0 and `go`=0 one cycle after 0x05 is accepted.
- In transit, `OK2Move`=0 for 3·`BUZZ_HALF` clks (`BUZZ_HALF`=4 in sim) → `go`=0; `buzz` toggles every 4 clks with `buzz_n` complementary; returns to `buzz`=0, `buzz_n`=1 when `OK2Move`=1.
- `cmd_rdy` with `cmd`=0x3F (STOP) and `ID_vld` with `ID`=0x05 in the same cycle while going to 0x05 → both clears pulse; stop via command; no double acknowledge.
- ID 0x05 in IDLE, and `cmd`=0x80 in TRANSIT → acknowledged; state and `dest` unchanged.
- `rst` asserted while `in_transit`=1 and `clr_ID_vld` pending → next clk all outputs at reset values, no clear pulse.
